// File: rtl/sdram_ctrl.sv
// Closed-page, burst-1 SDRAM command controller with one outstanding request.
// Sequences init, access and refresh commands from a valid/ready word interface.
module sdram_ctrl #(
  parameter int unsigned INIT_CYCLES      = 100,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_RFC            = 7,
  parameter int unsigned T_WR             = 2,
  parameter int unsigned CAS_LATENCY      = 2,
  parameter int unsigned REFRESH_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [26:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        sdram_cke,
  output logic        sdram_cs,
  output logic        sdram_ras,
  output logic        sdram_cas,
  output logic        sdram_we,
  output logic [13:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [3:0]  sdram_dqm,
  inout  wire  [31:0] sdram_dq
);

  localparam int unsigned MODE_NOPS = 2;
  localparam int unsigned M0 = (INIT_CYCLES > T_RFC) ? INIT_CYCLES : T_RFC;
  localparam int unsigned M1 = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int unsigned M2 = (T_WR > CAS_LATENCY) ? T_WR : CAS_LATENCY;
  localparam int unsigned M3 = (M0 > M1) ? M0 : M1;
  localparam int unsigned M4 = (M2 > MODE_NOPS) ? M2 : MODE_NOPS;
  localparam int unsigned CNT_MAX = (M3 > M4) ? M3 : M4;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam int unsigned REF_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  // {cs, ras, cas, we}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MODE = 4'b0000;

  localparam logic [13:0] A_ALL_BANKS = 14'h0400;
  localparam logic [13:0] MODE_WORD   = {7'b0, 3'(CAS_LATENCY), 1'b0, 3'b000};

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MODE,
    S_IDLE, S_ACTIVATE, S_RD, S_RD_WAIT, S_WR, S_WR_REC, S_PRECHARGE, S_REFRESH
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_cmd, w_cmd_nxt;
  logic [13:0]        r_a, w_a_nxt;
  logic [1:0]         r_ba, w_ba_nxt;
  logic [3:0]         r_dqm, w_dqm_nxt;
  logic               r_dq_oe, w_dq_oe_nxt;
  logic [31:0]        r_dq_out, w_dq_out_nxt;
  logic               r_cke;
  logic               r_ready, w_ready_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]        r_rsp_rdata, w_rsp_rdata_nxt;
  logic [31:0]        r_cap, w_cap_nxt;
  logic               r_we, w_we_nxt;
  logic [8:0]         r_col, w_col_nxt;
  logic [1:0]         r_bank, w_bank_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [3:0]         r_wstrb, w_wstrb_nxt;
  logic               r_ref_en, w_ref_en_nxt;
  logic [REF_W-1:0]   r_ref_cnt, w_ref_cnt_nxt;
  logic               r_ref_pend, w_ref_pend_nxt;
  logic               w_ref_wrap;
  logic               w_ref_clr;
  logic               w_cnt_zero;
  logic               w_unused;

  assign w_unused = ^req_addr[1:0];
  assign w_cnt_zero = (r_cnt == '0);

  assign sdram_dq  = r_dq_oe ? r_dq_out : 32'bz;
  assign sdram_cke = r_cke;
  assign sdram_cs  = r_cmd[3];
  assign sdram_ras = r_cmd[2];
  assign sdram_cas = r_cmd[1];
  assign sdram_we  = r_cmd[0];
  assign sdram_a   = r_a;
  assign sdram_ba  = r_ba;
  assign sdram_dqm = r_dqm;
  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  // Refresh timer runs once init has completed; pending stays set until REFRESH issues
  assign w_ref_wrap     = r_ref_en && (r_ref_cnt == REF_W'(REFRESH_INTERVAL - 1));
  assign w_ref_cnt_nxt  = !r_ref_en ? r_ref_cnt : (w_ref_wrap ? '0 : r_ref_cnt + REF_W'(1));
  assign w_ref_pend_nxt = w_ref_wrap | (r_ref_pend & ~w_ref_clr);
  assign w_ref_en_nxt   = r_ref_en | (w_state_nxt == S_IDLE);
  assign w_ready_nxt    = (w_state_nxt == S_IDLE) && !w_ref_pend_nxt;

  // Next state and next registered pin values
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
    w_cmd_nxt       = CMD_NOP;
    w_a_nxt         = r_a;
    w_ba_nxt        = r_ba;
    w_dqm_nxt       = 4'hF;
    w_dq_oe_nxt     = 1'b0;
    w_dq_out_nxt    = r_dq_out;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_cap_nxt       = r_cap;
    w_we_nxt        = r_we;
    w_col_nxt       = r_col;
    w_bank_nxt      = r_bank;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_ref_clr       = 1'b0;

    case (r_state)
      S_INIT_WAIT: if (w_cnt_zero) begin
        w_state_nxt = S_INIT_PRE;
        w_cmd_nxt   = CMD_PRE;
        w_a_nxt     = A_ALL_BANKS;
        w_cnt_nxt   = CNT_W'(T_RP - 1);
      end
      S_INIT_PRE: if (w_cnt_zero) begin
        w_state_nxt = S_INIT_REF1;
        w_cmd_nxt   = CMD_REF;
        w_cnt_nxt   = CNT_W'(T_RFC - 1);
      end
      S_INIT_REF1: if (w_cnt_zero) begin
        w_state_nxt = S_INIT_REF2;
        w_cmd_nxt   = CMD_REF;
        w_cnt_nxt   = CNT_W'(T_RFC - 1);
      end
      S_INIT_REF2: if (w_cnt_zero) begin
        w_state_nxt = S_INIT_MODE;
        w_cmd_nxt   = CMD_MODE;
        w_a_nxt     = MODE_WORD;
        w_ba_nxt    = 2'b00;
        w_cnt_nxt   = CNT_W'(MODE_NOPS);
      end
      S_INIT_MODE: if (w_cnt_zero) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (r_ref_pend) begin
          w_state_nxt = S_REFRESH;
          w_cmd_nxt   = CMD_REF;
          w_cnt_nxt   = CNT_W'(T_RFC - 1);
          w_ref_clr   = 1'b1;
        end else if (req_valid && r_ready) begin
          w_state_nxt = S_ACTIVATE;
          w_cmd_nxt   = CMD_ACT;
          w_a_nxt     = req_addr[26:13];
          w_ba_nxt    = req_addr[12:11];
          w_cnt_nxt   = CNT_W'(T_RCD - 1);
          w_we_nxt    = req_we;
          w_col_nxt   = req_addr[10:2];
          w_bank_nxt  = req_addr[12:11];
          w_wdata_nxt = req_wdata;
          w_wstrb_nxt = req_wstrb;
        end
      end
      S_ACTIVATE: if (w_cnt_zero) begin
        w_a_nxt  = {5'b0, r_col};
        w_ba_nxt = r_bank;
        if (r_we) begin
          w_state_nxt  = S_WR;
          w_cmd_nxt    = CMD_WR;
          w_dqm_nxt    = ~r_wstrb;
          w_dq_oe_nxt  = 1'b1;
          w_dq_out_nxt = r_wdata;
        end else begin
          w_state_nxt = S_RD;
          w_cmd_nxt   = CMD_RD;
          w_dqm_nxt   = 4'h0;
        end
      end
      S_RD: begin
        w_state_nxt = S_RD_WAIT;
        w_cnt_nxt   = CNT_W'(CAS_LATENCY);
      end
      // Capture lands CAS_LATENCY edges after the device saw READ; respond one cycle later
      S_RD_WAIT: begin
        if (r_cnt == CNT_W'(1)) w_cap_nxt = sdram_dq;
        if (w_cnt_zero) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_cap;
          w_state_nxt     = S_PRECHARGE;
          w_cmd_nxt       = CMD_PRE;
          w_a_nxt         = A_ALL_BANKS;
          w_cnt_nxt       = CNT_W'(T_RP - 1);
        end
      end
      S_WR: begin
        w_state_nxt     = S_WR_REC;
        w_rsp_valid_nxt = 1'b1;
        w_cnt_nxt       = CNT_W'(T_WR - 1);
      end
      S_WR_REC: if (w_cnt_zero) begin
        w_state_nxt = S_PRECHARGE;
        w_cmd_nxt   = CMD_PRE;
        w_a_nxt     = A_ALL_BANKS;
        w_cnt_nxt   = CNT_W'(T_RP - 1);
      end
      S_PRECHARGE: if (w_cnt_zero) w_state_nxt = S_IDLE;
      S_REFRESH:   if (w_cnt_zero) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_INIT_WAIT;
      r_cnt       <= CNT_W'(INIT_CYCLES);
      r_cmd       <= CMD_NOP;
      r_a         <= '0;
      r_ba        <= '0;
      r_dqm       <= 4'hF;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
      r_cke       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_cap       <= '0;
      r_we        <= 1'b0;
      r_col       <= '0;
      r_bank      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_ref_en    <= 1'b0;
      r_ref_cnt   <= '0;
      r_ref_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd       <= w_cmd_nxt;
      r_a         <= w_a_nxt;
      r_ba        <= w_ba_nxt;
      r_dqm       <= w_dqm_nxt;
      r_dq_oe     <= w_dq_oe_nxt;
      r_dq_out    <= w_dq_out_nxt;
      r_cke       <= 1'b1;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_cap       <= w_cap_nxt;
      r_we        <= w_we_nxt;
      r_col       <= w_col_nxt;
      r_bank      <= w_bank_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_ref_en    <= w_ref_en_nxt;
      r_ref_cnt   <= w_ref_cnt_nxt;
      r_ref_pend  <= w_ref_pend_nxt;
    end
  end

endmodule
